// File: rtl/ldpc_pkg.sv
// Shared definitions for the LDPC decoder scheduler family: default sizes, clog2 helper
// and the scheduler FSM state type.
package ldpc_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned D_DEF      = 5;
   localparam int unsigned N_COL_DEF  = 64;

   // Ceiling log2, never below 1 so derived widths stay legal.
   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 31; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return (r == 0) ? 1 : r;
   endfunction

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} sched_state_e;

endpackage

// File: rtl/vnu.sv
// Variable-node unit: combinational sum of channel LLR and D R messages, extrinsic Q
// outputs (wrapping, unsaturated) and the hard decision.
module vnu import ldpc_pkg::*; #(
   parameter int unsigned data_w = DATA_W_DEF,
   parameter int unsigned D      = D_DEF
) (
   input  logic [data_w-1:0]   l,
   input  logic [data_w*D-1:0] r,
   output logic [data_w*D-1:0] q,
   output logic                dec
);

   localparam int unsigned ext_w = clog2(D + 1);
   localparam int unsigned sum_w = data_w + ext_w;

   logic signed [sum_w-1:0] s;

   always_comb begin
      q = '0;
      s = sum_w'(signed'(l));
      for (int i = 0; i < D; i++) begin
         s = s + sum_w'(signed'(r[i*data_w +: data_w]));
      end
      for (int i = 0; i < D; i++) begin
         q[i*data_w +: data_w] = data_w'(s - sum_w'(signed'(r[i*data_w +: data_w])));
      end
      dec = s[sum_w-1];
   end

endmodule

// File: rtl/vnu_col_sched.sv
// Column scheduler for one variable-node pass: streams every column through a single vnu,
// writes Q back three cycles after the read, and tracks hard-decision flips.
module vnu_col_sched import ldpc_pkg::*; #(
   parameter int unsigned data_w = DATA_W_DEF,
   parameter int unsigned D      = D_DEF,
   parameter int unsigned N_COL  = N_COL_DEF,
   localparam int unsigned addr_w = clog2(N_COL)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic                rd_en,
   output logic [addr_w-1:0]   rd_addr,
   input  logic [data_w-1:0]   rd_l,
   input  logic [data_w*D-1:0] rd_r,
   output logic                wr_en,
   output logic [addr_w-1:0]   wr_addr,
   output logic [data_w*D-1:0] wr_q,
   output logic [N_COL-1:0]    dec_vec,
   output logic [addr_w:0]     flip_cnt
);

   localparam logic [addr_w-1:0] last_col = addr_w'(N_COL - 1);

   sched_state_e state;
   logic [1:0]   drain_cnt;

   // Stage 0: read issued last cycle, memory data arrives now.
   logic                v0;
   logic [addr_w-1:0]   a0;
   // Stage 1: vnu input registers loaded.
   logic                v1;
   logic [addr_w-1:0]   a1;
   logic [data_w-1:0]   l_q;
   logic [data_w*D-1:0] r_q;
   logic                dec_q;

   logic [data_w*D-1:0] q;
   logic                dec;

   vnu #(
      .data_w (data_w),
      .D      (D)
   ) u_vnu (
      .l   (l_q),
      .r   (r_q),
      .q   (q),
      .dec (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= StIdle;
         drain_cnt <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         rd_en     <= 1'b0;
         rd_addr   <= '0;
         v0        <= 1'b0;
         a0        <= '0;
         v1        <= 1'b0;
         a1        <= '0;
         l_q       <= '0;
         r_q       <= '0;
         dec_q     <= 1'b0;
         wr_en     <= 1'b0;
         wr_addr   <= '0;
         wr_q      <= '0;
         dec_vec   <= '0;
         flip_cnt  <= '0;
      end else begin
         v0 <= rd_en;
         a0 <= rd_addr;
         v1 <= v0;
         a1 <= a0;
         if (v0) begin
            l_q <= rd_l;
            r_q <= rd_r;
         end
         wr_en   <= v1;
         wr_addr <= a1;
         if (v1) begin
            wr_q  <= q;
            dec_q <= dec;
         end
         // A write that is on the bus this cycle always lands, even if abort arrives with it.
         if (wr_en) begin
            dec_vec[wr_addr] <= dec_q;
            if (dec_vec[wr_addr] != dec_q) flip_cnt <= flip_cnt + (addr_w+1)'(1);
         end

         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (start && !abort) begin
                  state    <= StRun;
                  busy     <= 1'b1;
                  rd_en    <= 1'b1;
                  rd_addr  <= '0;
                  flip_cnt <= '0;
               end
            end
            StRun: begin
               if (rd_addr == last_col) begin
                  state     <= StDrain;
                  rd_en     <= 1'b0;
                  rd_addr   <= '0;
                  drain_cnt <= '0;
               end else begin
                  rd_addr <= rd_addr + addr_w'(1);
               end
            end
            StDrain: begin
               drain_cnt <= drain_cnt + 2'd1;
               if (drain_cnt == 2'd2) begin
                  state <= StFin;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            StFin: state <= StIdle;
            default: state <= StIdle;
         endcase

         if (abort && state != StIdle) begin
            state   <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            v0      <= 1'b0;
            v1      <= 1'b0;
            wr_en   <= 1'b0;
         end
      end
   end

endmodule

// File: doc/vnu_col_sched.md
Name: vnu_col_sched

Overview:
- Column scheduler for one variable-node pass of the LDPC decoder.
- Streams N_COL columns from the message memory through a single internal vnu instance.
- Writes the resulting Q messages back and maintains the hard-decision vector.
- Counts hard-decision flips against the previous pass; the iteration controller uses this count for early termination.

Parameters:
- data_w, 8, width of one LLR / message (two's complement)
- D, 5, column degree (R messages per column)
- N_COL, 64, columns per pass
- addr_w, clog2(N_COL), column address width (derived localparam)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begin a pass
- abort  in  1  synchronous pass cancel
- busy  out  1  high from the first RUN cycle until done
- done  out  1  single-cycle pulse when the pass completes
- rd_en  out  1  message-memory read strobe
- rd_addr  out  addr_w  column read address
- rd_l  in  data_w  channel LLR, valid the cycle after rd_en
- rd_r  in  data_w*D  R messages, valid the cycle after rd_en
- wr_en  out  1  Q write strobe
- wr_addr  out  addr_w  column write address
- wr_q  out  data_w*D  Q messages
- dec_vec  out  N_COL  hard decisions, bit c = column c
- flip_cnt  out  addr_w+1  number of dec_vec bits changed in this pass

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_q, dec_vec and flip_cnt are all 0. FSM goes to IDLE.
- FSM states: IDLE, RUN, DRAIN, FIN.
- IDLE:
  - start=1 -> RUN; col counter = 0; flip_cnt = 0.
  - dec_vec is kept so it can be compared against the previous pass.
- RUN:
  - rd_en=1, rd_addr=col; col increments each cycle.
  - After issuing col=N_COL-1 -> DRAIN.
- DRAIN: lasts 3 cycles, long enough for the last column to be written. Then -> FIN.
- FIN: done=1 for exactly one cycle; busy=0 in that cycle; -> IDLE.
- Pipeline, with rd_en issued in cycle t:
  - Cycle t+1: rd_l/rd_r are registered into the vnu input registers at the end of the cycle.
  - Cycle t+2: vnu evaluates combinationally; q and dec are registered at the end of the cycle.
  - Cycle t+3: wr_en=1, wr_addr=col, wr_q=registered q.
- Fixed latency: read to write is 3 cycles. Start cycle S -> done at cycle S+N_COL+4.
- One column per cycle; there is no backpressure. The memory must accept one write per cycle.
- Arithmetic is that of vnu:
  - s = l + sum(r_i), sign-extended to data_w+clog2-style ext bits.
  - q_i = s - r_i, truncated to data_w with no saturation.
  - dec = sign of s.
- dec update: in the write cycle for column c, dec_vec[c] <= dec. flip_cnt increments if the new dec differs from the old dec_vec[c].
- A valid-bit shift chain tracks each pipeline stage. The address travels along with the data.
- start while busy (RUN/DRAIN/FIN) is ignored.
- abort in any non-IDLE state:
  - Next cycle: IDLE, rd_en=0, wr_en=0, all valid bits cleared, no done pulse.
  - dec_vec and flip_cnt keep whatever was written before the abort.
- abort and start in the same cycle while IDLE: abort wins; stay in IDLE.
- Asynchronous reset mid-pass: immediate return to reset values; no write completes.

Decomposition:
- Shared package ldpc_pkg holds:
  - the clog2 function
  - the default data_w, D and N_COL
  - the FSM state enum for the scheduler family
- One sub-module: the existing vnu, instantiated once with data_w and D passed through.
- The scheduler owns all registers.

Test Plan:
- Basic column (N_COL=4, D=5, data_w=8): col0 l=10, r={1,2,3,4,5} -> wr_addr=0, wr_q lanes={24,23,22,21,20}, dec_vec[0]=0, wr_en asserted exactly 3 cycles after rd_en of col0.
- Negative sum: col1 l=0xEC (-20), all r=0xFF (-1) -> q lanes all 0xE8 (-24), dec_vec[1]=1, flip_cnt=1 when starting from reset.
- Wrap-around: col2 l=127, all r=127 -> s=762, q lanes=0x7B (truncated), dec=0. Checks that no saturation is applied.
- Timing and flip count:
  - Full pass with start pulse at cycle S -> rd_en high cycles S+1..S+4, wr_en high S+4..S+7, done single pulse at S+8, busy low again at S+8.
  - Second pass with signs inverted on 3 columns -> flip_cnt=3.
- Control corner cases:
  - start re-pulsed at S+3 -> ignored, only one done.
  - abort at S+3 -> no done, wr_en stops after the abort cycle, dec_vec holds only the columns already written, the next start runs cleanly.
- rst_n low at S+5 -> all outputs 0 asynchronously, no further writes.
